issue_scoreboard: RTL and testbench

//  Dual-issue RAW/structural hazard scheduler at ID for the ex1..ex4/wb bypass network.
//  - Tracks, per architectural register, cycles until its newest pending result is forwardable.
//  - Grants issue to slot i1/i2 only when every source is either bypassable or already in the ARF.
//  - Arbitrates the single LSU between the two slots.

---
 rtl/issue_scoreboard_pkg.sv | 23 ++
 rtl/sb_src_check.sv | 17 +
 rtl/issue_scoreboard.sv | 149 ++++++++++++++
 tb/tb_issue_scoreboard.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared constants, types and helpers for the dual-issue scoreboard.
// Latency codes are cycles a consumer must wait after its producer issues.
package issue_scoreboard_pkg;

    localparam int unsigned LA64_ARF_SEL      = 5;
    localparam int unsigned LA64_ARF_NUM      = 32;
    localparam int unsigned LA64_MAX_LAT      = 4;
    localparam int unsigned LA64_SB_LAT_WIDTH = $clog2(LA64_MAX_LAT + 1);

    typedef logic [LA64_ARF_SEL-1:0]      reg_idx_t;
    typedef logic [LA64_SB_LAT_WIDTH-1:0] lat_t;

    localparam lat_t LA64_LAT_ALU  = lat_t'(0);
    localparam lat_t LA64_LAT_LOAD = lat_t'(2);
    localparam lat_t LA64_LAT_MUL  = lat_t'(3);

    // True when a reader of rs depends on a same-cycle writer of rd; r0 never carries data.
    function automatic logic raw_hit(input logic we, input reg_idx_t rd,
                                     input logic re, input reg_idx_t rs);
        return we & (rd != '0) & re & (rs == rd);
    endfunction

endpackage

// File: rtl/sb_src_check.sv
// One source-operand lookup: the operand is ready when unread, r0, or its
// producer count has drained to zero.
module sb_src_check
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned ARF_NUM = LA64_ARF_NUM,
    parameter int unsigned LW      = LA64_SB_LAT_WIDTH
) (
    input  logic                        re,
    input  logic [LA64_ARF_SEL-1:0]     raddr,
    input  logic [ARF_NUM-1:0][LW-1:0]  cnt,
    output logic                        ok
);

    assign ok = ~re | (raddr == '0) | (cnt[raddr] == '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue RAW/structural hazard scheduler at ID with per-register bypass countdown.
// Optional performance counters are enabled with ISSUE_SCOREBOARD_PERF_EN.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_LAT = LA64_MAX_LAT,
    parameter int unsigned ARF_NUM = LA64_ARF_NUM,
    localparam int unsigned LW     = $clog2(MAX_LAT + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_pipe_stall,
    input  logic                    i_flush,

    input  logic                    i_i1_vld,
    input  logic                    i_i1_rj_re,
    input  logic                    i_i1_rk_re,
    input  logic [LA64_ARF_SEL-1:0] i_i1_rj_raddr,
    input  logic [LA64_ARF_SEL-1:0] i_i1_rk_raddr,
    input  logic                    i_i1_rd_we,
    input  logic [LA64_ARF_SEL-1:0] i_i1_rd_waddr,
    input  logic [LW-1:0]           i_i1_lat,
    input  logic                    i_i1_is_mem,

    input  logic                    i_i2_vld,
    input  logic                    i_i2_rj_re,
    input  logic                    i_i2_rk_re,
    input  logic [LA64_ARF_SEL-1:0] i_i2_rj_raddr,
    input  logic [LA64_ARF_SEL-1:0] i_i2_rk_raddr,
    input  logic                    i_i2_rd_we,
    input  logic [LA64_ARF_SEL-1:0] i_i2_rd_waddr,
    input  logic [LW-1:0]           i_i2_lat,
    input  logic                    i_i2_is_mem,

    output logic                    o_i1_issue,
    output logic                    o_i2_issue,
    output logic                    o_id_stall,
    output logic                    o_i2_split
`ifdef ISSUE_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]             o_raw_stall_cnt,
    output logic [31:0]             o_split_cnt
`endif
);

    logic [ARF_NUM-1:0][LW-1:0] cnt_q;
    logic [ARF_NUM-1:0][LW-1:0] cnt_d;

    logic i1_rj_ok, i1_rk_ok, i2_rj_ok, i2_rk_ok;
    logic i1_src_ok, i2_src_ok;
    logic i2_raw_on_i1, lsu_conflict;

    sb_src_check #(.ARF_NUM(ARF_NUM), .LW(LW)) u_i1_rj (
        .re    (i_i1_rj_re),
        .raddr (i_i1_rj_raddr),
        .cnt   (cnt_q),
        .ok    (i1_rj_ok)
    );

    sb_src_check #(.ARF_NUM(ARF_NUM), .LW(LW)) u_i1_rk (
        .re    (i_i1_rk_re),
        .raddr (i_i1_rk_raddr),
        .cnt   (cnt_q),
        .ok    (i1_rk_ok)
    );

    sb_src_check #(.ARF_NUM(ARF_NUM), .LW(LW)) u_i2_rj (
        .re    (i_i2_rj_re),
        .raddr (i_i2_rj_raddr),
        .cnt   (cnt_q),
        .ok    (i2_rj_ok)
    );

    sb_src_check #(.ARF_NUM(ARF_NUM), .LW(LW)) u_i2_rk (
        .re    (i_i2_rk_re),
        .raddr (i_i2_rk_raddr),
        .cnt   (cnt_q),
        .ok    (i2_rk_ok)
    );

    assign i1_src_ok = i1_rj_ok & i1_rk_ok;
    assign i2_src_ok = i2_rj_ok & i2_rk_ok;

    // i2 cannot bypass from i1 in the same cycle: the result does not exist yet.
    assign i2_raw_on_i1 = raw_hit(i_i1_rd_we, i_i1_rd_waddr, i_i2_rj_re, i_i2_rj_raddr)
                        | raw_hit(i_i1_rd_we, i_i1_rd_waddr, i_i2_rk_re, i_i2_rk_raddr);
    assign lsu_conflict = i_i1_is_mem & i_i2_is_mem;

    assign o_i1_issue = i_i1_vld & ~i_pipe_stall & ~i_flush & i1_src_ok;
    assign o_i2_issue = o_i1_issue & i_i2_vld & i2_src_ok & ~i2_raw_on_i1 & ~lsu_conflict;
    assign o_id_stall = i_i1_vld & ~o_i1_issue;
    assign o_i2_split = o_i1_issue & i_i2_vld & ~o_i2_issue;

    // Set beats decrement, and i2 is written last so it wins a same-rd pair.
    always_comb begin
        cnt_d = cnt_q;
        if (i_flush) begin
            cnt_d = '0;
        end else if (!i_pipe_stall) begin
            for (int r = 0; r < ARF_NUM; r++) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - LW'(1);
                end
            end
            if (o_i1_issue && i_i1_rd_we && (i_i1_rd_waddr != '0)) begin
                cnt_d[i_i1_rd_waddr] = i_i1_lat;
            end
            if (o_i2_issue && i_i2_rd_we && (i_i2_rd_waddr != '0)) begin
                cnt_d[i_i2_rd_waddr] = i_i2_lat;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef ISSUE_SCOREBOARD_PERF_EN
    logic [31:0] raw_stall_cnt_q;
    logic [31:0] split_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            raw_stall_cnt_q <= '0;
            split_cnt_q     <= '0;
        end else if (!i_pipe_stall) begin
            if (i_i1_vld && !i1_src_ok) begin
                raw_stall_cnt_q <= raw_stall_cnt_q + 32'd1;
            end
            if (o_i2_split) begin
                split_cnt_q <= split_cnt_q + 32'd1;
            end
        end
    end

    assign o_raw_stall_cnt = raw_stall_cnt_q;
    assign o_split_cnt     = split_cnt_q;
`endif

    lat_legal_i1: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_i1_issue && i_i1_rd_we) |-> (i_i1_lat <= LW'(MAX_LAT)));
    lat_legal_i2: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_i2_issue && i_i2_rd_we) |-> (i_i2_lat <= LW'(MAX_LAT)));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: each cycle's expected issue/stall/split
// outcome is queued with its stimulus and compared before the next clock edge.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pipe_stall, flush;
    logic       i1_vld, i1_rj_re, i1_rk_re, i1_rd_we, i1_is_mem;
    logic [4:0] i1_rj, i1_rk, i1_rd;
    logic [2:0] i1_lat;
    logic       i2_vld, i2_rj_re, i2_rk_re, i2_rd_we, i2_is_mem;
    logic [4:0] i2_rj, i2_rk, i2_rd;
    logic [2:0] i2_lat;
    logic       i1_issue, i2_issue, id_stall, i2_split;
`ifdef ISSUE_SCOREBOARD_PERF_EN
    logic [31:0] raw_stall_cnt, split_cnt;
`endif

    issue_scoreboard dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pipe_stall  (pipe_stall),
        .i_flush       (flush),
        .i_i1_vld      (i1_vld),
        .i_i1_rj_re    (i1_rj_re),
        .i_i1_rk_re    (i1_rk_re),
        .i_i1_rj_raddr (i1_rj),
        .i_i1_rk_raddr (i1_rk),
        .i_i1_rd_we    (i1_rd_we),
        .i_i1_rd_waddr (i1_rd),
        .i_i1_lat      (i1_lat),
        .i_i1_is_mem   (i1_is_mem),
        .i_i2_vld      (i2_vld),
        .i_i2_rj_re    (i2_rj_re),
        .i_i2_rk_re    (i2_rk_re),
        .i_i2_rj_raddr (i2_rj),
        .i_i2_rk_raddr (i2_rk),
        .i_i2_rd_we    (i2_rd_we),
        .i_i2_rd_waddr (i2_rd),
        .i_i2_lat      (i2_lat),
        .i_i2_is_mem   (i2_is_mem),
        .o_i1_issue    (i1_issue),
        .o_i2_issue    (i2_issue),
        .o_id_stall    (id_stall),
        .o_i2_split    (i2_split)
`ifdef ISSUE_SCOREBOARD_PERF_EN
        ,
        .o_raw_stall_cnt (raw_stall_cnt),
        .o_split_cnt     (split_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  i1;
        logic  i2;
        logic  st;
        logic  sp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    task automatic expect_out(input string tag, input logic e1, input logic e2,
                              input logic est, input logic esp);
        exp_t e;
        e.tag = tag;
        e.i1  = e1;
        e.i2  = e2;
        e.st  = est;
        e.sp  = esp;
        exp_q.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        check("sb_nonempty", logic'(exp_q.size() != 0), 1'b1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({e.tag, ".i1_issue"}, i1_issue, e.i1);
        check({e.tag, ".i2_issue"}, i2_issue, e.i2);
        check({e.tag, ".id_stall"}, id_stall, e.st);
        check({e.tag, ".i2_split"}, i2_split, e.sp);
    endtask

    task automatic clear_inputs();
        pipe_stall = 0; flush = 0;
        i1_vld = 0; i1_rj_re = 0; i1_rk_re = 0; i1_rd_we = 0; i1_is_mem = 0;
        i1_rj = 0; i1_rk = 0; i1_rd = 0; i1_lat = 0;
        i2_vld = 0; i2_rj_re = 0; i2_rk_re = 0; i2_rd_we = 0; i2_is_mem = 0;
        i2_rj = 0; i2_rk = 0; i2_rd = 0; i2_lat = 0;
    endtask

    task automatic set_i1(input logic rje, input logic [4:0] rj, input logic rke,
                          input logic [4:0] rk, input logic we, input logic [4:0] rd,
                          input logic [2:0] lat, input logic mem);
        i1_vld = 1; i1_rj_re = rje; i1_rj = rj; i1_rk_re = rke; i1_rk = rk;
        i1_rd_we = we; i1_rd = rd; i1_lat = lat; i1_is_mem = mem;
    endtask

    task automatic set_i2(input logic rje, input logic [4:0] rj, input logic rke,
                          input logic [4:0] rk, input logic we, input logic [4:0] rd,
                          input logic [2:0] lat, input logic mem);
        i2_vld = 1; i2_rj_re = rje; i2_rj = rj; i2_rk_re = rke; i2_rk = rk;
        i2_rd_we = we; i2_rd = rd; i2_lat = lat; i2_is_mem = mem;
    endtask

    // Inputs are driven 1ns after posedge; outputs are sampled on the negedge.
    task automatic cycle(input string tag, input logic e1, input logic e2,
                         input logic est, input logic esp);
        expect_out(tag, e1, e2, est, esp);
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        clear_inputs();
        #2;
        expect_out("reset", 0, 0, 0, 0);
        compare_outputs();
        #1 rst_n = 1;
        @(posedge clk);
        #1;

        // ALU producer then immediate consumer via ex1 bypass.
        set_i1(0, 0, 0, 0, 1, 5, LA64_LAT_ALU, 0);  cycle("alu_r5", 1, 0, 0, 0);
        set_i1(1, 5, 0, 0, 0, 0, 0, 0);             cycle("use_r5", 1, 0, 0, 0);

        // Load-use: two stall cycles, issue on the third.
        set_i1(0, 0, 0, 0, 1, 4, LA64_LAT_LOAD, 1); cycle("ld_r4", 1, 0, 0, 0);
        set_i1(0, 0, 1, 4, 0, 0, 0, 0);             cycle("ld_use0", 0, 0, 1, 0);
        set_i1(0, 0, 1, 4, 0, 0, 0, 0);             cycle("ld_use1", 0, 0, 1, 0);
        set_i1(0, 0, 1, 4, 0, 0, 0, 0);             cycle("ld_use2", 1, 0, 0, 0);

        // Intra-pair RAW splits; held i2 moves to i1.
        set_i1(0, 0, 0, 0, 1, 7, LA64_LAT_ALU, 0);
        set_i2(1, 7, 0, 0, 1, 8, LA64_LAT_ALU, 0);  cycle("pair_raw", 1, 0, 0, 1);
        set_i1(1, 7, 0, 0, 1, 8, LA64_LAT_ALU, 0);  cycle("split_i1", 1, 0, 0, 0);

        // LSU structural conflict.
        set_i1(0, 0, 0, 0, 1, 20, LA64_LAT_LOAD, 1);
        set_i2(1, 21, 1, 22, 0, 0, 0, 1);           cycle("pair_mem", 1, 0, 0, 1);
        set_i1(1, 21, 1, 22, 0, 0, 0, 1);           cycle("mem_i1", 1, 0, 0, 0);

        // Independent pair dual-issues; i2's destination becomes pending.
        set_i1(1, 1, 0, 0, 1, 23, LA64_LAT_ALU, 0);
        set_i2(1, 2, 0, 0, 1, 24, LA64_LAT_LOAD, 0); cycle("pair_ok", 1, 1, 0, 0);
        set_i1(1, 24, 0, 0, 0, 0, 0, 0);            cycle("i2_set0", 0, 0, 1, 0);
        set_i1(1, 24, 0, 0, 0, 0, 0, 0);            cycle("i2_set1", 0, 0, 1, 0);
        set_i1(1, 24, 0, 0, 0, 0, 0, 0);            cycle("i2_set2", 1, 0, 0, 0);

        // In-order: a blocked i1 holds back a ready i2.
        set_i1(0, 0, 0, 0, 1, 25, LA64_LAT_LOAD, 1); cycle("ld_r25", 1, 0, 0, 0);
        set_i1(1, 25, 0, 0, 0, 0, 0, 0);
        set_i2(1, 3, 0, 0, 1, 26, LA64_LAT_ALU, 0); cycle("inorder", 0, 0, 1, 0);
        cycle("idle0", 0, 0, 0, 0);

        // WAW pair: i2's latency wins in both orders.
        set_i1(0, 0, 0, 0, 1, 3, LA64_LAT_MUL, 0);
        set_i2(0, 0, 0, 0, 1, 3, LA64_LAT_ALU, 0);  cycle("waw", 1, 1, 0, 0);
        set_i1(1, 3, 0, 0, 0, 0, 0, 0);             cycle("waw_rd", 1, 0, 0, 0);
        set_i1(0, 0, 0, 0, 1, 8, LA64_LAT_ALU, 0);
        set_i2(0, 0, 0, 0, 1, 8, LA64_LAT_MUL, 0);  cycle("waw2", 1, 1, 0, 0);
        set_i1(0, 0, 1, 8, 0, 0, 0, 0);             cycle("waw2_rd", 0, 0, 1, 0);
        cycle("idle1", 0, 0, 0, 0);
        cycle("idle2", 0, 0, 0, 0);

        // Newer writer with a smaller latency overwrites the pending count.
        set_i1(0, 0, 0, 0, 1, 12, LA64_LAT_LOAD, 1); cycle("ld_r12", 1, 0, 0, 0);
        set_i1(0, 0, 0, 0, 1, 12, LA64_LAT_ALU, 0);  cycle("alu_r12", 1, 0, 0, 0);
        set_i1(1, 12, 0, 0, 0, 0, 0, 0);             cycle("use_r12", 1, 0, 0, 0);

        // Pipe stall freezes counts and blocks issue.
        set_i1(0, 0, 0, 0, 1, 10, LA64_LAT_LOAD, 1); cycle("ld_r10", 1, 0, 0, 0);
        set_i1(1, 10, 0, 0, 0, 0, 0, 0); pipe_stall = 1; cycle("stall0", 0, 0, 1, 0);
        set_i1(1, 10, 0, 0, 0, 0, 0, 0); pipe_stall = 1; cycle("stall1", 0, 0, 1, 0);
        set_i1(1, 1, 0, 0, 0, 0, 0, 0);  pipe_stall = 1; cycle("stall_ok", 0, 0, 1, 0);
        set_i1(1, 10, 0, 0, 0, 0, 0, 0);             cycle("hold0", 0, 0, 1, 0);
        set_i1(1, 10, 0, 0, 0, 0, 0, 0);             cycle("hold1", 0, 0, 1, 0);
        set_i1(1, 10, 0, 0, 0, 0, 0, 0);             cycle("hold2", 1, 0, 0, 0);

        // Flush clears pending counts held through a stall.
        set_i1(0, 0, 0, 0, 1, 9, LA64_LAT_LOAD, 1);  cycle("ld_r9", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            pipe_stall = 1;
            cycle("stall_r9", 0, 0, 0, 0);
        end
        set_i1(1, 9, 0, 0, 0, 0, 0, 0); flush = 1;   cycle("flush", 0, 0, 1, 0);
        set_i1(1, 9, 0, 0, 0, 0, 0, 0);              cycle("post_flush", 1, 0, 0, 0);

        // Flush in the same cycle as a would-be issue: nothing is set.
        set_i1(0, 0, 0, 0, 1, 11, LA64_LAT_LOAD, 1); flush = 1; cycle("flush_iss", 0, 0, 1, 0);
        set_i1(1, 11, 0, 0, 0, 0, 0, 0);             cycle("use_r11", 1, 0, 0, 0);

        // r0 is never pending, even after an issued write to it.
        set_i1(0, 0, 0, 0, 1, 0, LA64_LAT_LOAD, 1);  cycle("wr_r0", 1, 0, 0, 0);
        set_i1(1, 0, 1, 0, 1, 0, LA64_LAT_LOAD, 0);
        set_i2(1, 0, 1, 0, 0, 0, 0, 0);              cycle("rd_r0", 1, 1, 0, 0);

        // Asynchronous reset clears pending counts without a clock edge.
        set_i1(0, 0, 0, 0, 1, 13, LA64_LAT_MUL, 0);  cycle("mul_r13", 1, 0, 0, 0);
        set_i1(1, 13, 0, 0, 0, 0, 0, 0);
        #1; expect_out("pre_rst", 0, 0, 1, 0);   compare_outputs();
        #1 rst_n = 0;
        #1; expect_out("async_rst", 1, 0, 0, 0); compare_outputs();
        clear_inputs();
        #1; expect_out("rst_zero", 0, 0, 0, 0);  compare_outputs();
        rst_n = 1;
        @(posedge clk);
        #1;
        set_i1(1, 13, 0, 0, 0, 0, 0, 0);             cycle("post_rst", 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
